time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//  Time-of-day core for the HH:MM:SS clock. Sits directly upstream of the seven-segment display stage.
//  - Derives a 1 Hz tick from the system clock and keeps hours, minutes and seconds.
//  - Runs a 4-state set-mode FSM driven by two push buttons.
//  - Drives the display stage's num2/num1/num0, blank and mode inputs, with the field being set blinking.
// PARAMETERS
//  CLK_HZ    50_000_000  system clock frequency; prescaler terminal count = CLK_HZ-1
//  BLINK_HZ  2           blink rate of the field being set; half-period = CLK_HZ/(2*BLINK_HZ) cycles
//  HOUR_MAX  23          last hour value before wrapping to 0 (24 h format)
// PORTS
//  clk       in   1  system clock; only clock in the block
//  reset     in   1  synchronous, active-high reset
//  key_mode  in   1  debounced, active-high level; a rising edge advances the mode
//  key_inc   in   1  debounced, active-high level; a rising edge increments the selected field
//  num2      out  8  hours, binary 0..HOUR_MAX (upper bits 0)
//  num1      out  8  minutes, binary 0..59
//  num0      out  8  seconds, binary 0..59
//  blank     out  4  per-field lit enable, 1 = lit: [3] hours, [2] minutes, [1] seconds, [0] reserved (always 1)
//  mode      out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
// BEHAVIOUR
//  Reset: all outputs registered. Sync reset gives num2=num1=num0=0, mode=RUN, blank=4'b1111,
//    prescaler=0, blink counter=0, blink phase=lit, key history regs=0. Reset overrides all other inputs.
//  Edge detect: key_x_q <= key_x; a pulse fires on a clock edge where key_x=1 and key_x_q=0.
//    The effect shows on the outputs right after that same edge. A held key gives exactly one pulse.
//  Prescaler: counts 0..CLK_HZ-1 in every mode; tick=1 for one cycle at CLK_HZ-1, then returns to 0.
//  RUN: on tick, seconds +1.
//    59->0 carries minutes +1; minutes 59->0 carries hours +1; hours HOUR_MAX->0. All carries in one cycle.
//    inc pulses are ignored in RUN.
//  SET_* states: time counting is frozen and ticks are ignored.
//    inc pulse increments only the selected field and wraps (59->0 or HOUR_MAX->0) with no carry to other fields.
//  FSM: each mode pulse steps RUN->SET_HR->SET_MIN->SET_SEC->RUN.
//    Entering RUN from SET_SEC clears the prescaler, so the first second after setting is a full second.
//  Simultaneous mode and inc pulses: the mode pulse wins and inc is discarded in that cycle.
//  Blink:
//    - In a SET state, the blank bit of the selected field toggles every half-period; all other bits stay 1.
//    - Every mode change and every accepted inc restarts the blink counter with phase=lit, so the new value shows at once.
//    - In RUN, blank=4'b1111.
//  Reset mid-set: returns to RUN at 00:00:00 on the next edge; any partial edit is lost.
// STRUCTURE
//  Shared package clock_pkg: mode encodings (MODE_RUN..MODE_SET_SEC), SEC_MAX=59, MIN_MAX=59.
//  One sub-module, wrap_counter #(MAX, W): a registered counter with ports clk, reset, en, out, wrap.
//    - en increments the count; wrap=1 combinationally when count==MAX && en.
//    - Instantiated three times (seconds, minutes, hours), with the carry chain built from wrap.
//  The prescaler, blink timer, edge detectors and FSM live in the top module.
// TESTING  (sim with CLK_HZ=10, BLINK_HZ=1, so one tick every 10 cycles and blink half-period 5 cycles)
//  1. Hold reset 2 cycles, then release. Required: 0/0/0, blank=1111, mode=0. After 10 cycles num0=1; after 600 cycles num1=1, num0=0.
//  2. Set 23:59:59 via the buttons, return to RUN, wait 10 cycles. Required: 0/0/0 in one step.
//  3. One key_mode rise. Required: mode=1, blank[3] toggles every 5 cycles, blank[2:0]=111, num0 unchanged over 50 cycles.
//  4. SET_HR with hours=23: inc gives hours=0. SET_MIN with minutes=59: inc gives minutes=0 and hours unchanged.
//     key_inc held high 20 cycles gives a single +1.
//  5. In SET_MIN, key_mode and key_inc rise in the same cycle. Required: mode=3, minutes unchanged, blank[1] lit at once.
//  6. Reset asserted during SET_SEC at 12:34:56. Required: the next edge gives mode=0, 00:00:00, blank=1111.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS time-of-day core: mode encodings,
// field limits and a counter-width helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/time_keeper_wrap_counter.sv
// Registered 0..MAX counter; advances on en, wrap flags the MAX->0 step in the
// same cycle so callers can chain carries combinationally.
module wrap_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] out,
  output logic         wrap
);

  logic at_max;

  assign at_max = (out == W'(MAX));
  assign wrap   = en && at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (en) begin
      out <= at_max ? '0 : out + 1'b1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day core: 1 Hz prescaler, HH:MM:SS counters, two-button set-mode FSM
// and blink of the field being set. Outputs are registered, one edge after a key rises.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] num2,
  output logic [7:0] num1,
  output logic [7:0] num0,
  output logic [3:0] blank,
  output logic [1:0] mode
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = cnt_width(CLK_HZ - 1);
  localparam int BW   = cnt_width(HALF - 1);
  localparam int HW   = cnt_width(HOUR_MAX);
  localparam int MW   = cnt_width(MIN_MAX);
  localparam int SW   = cnt_width(SEC_MAX);

  logic          key_mode_q;
  logic          key_inc_q;
  logic          mode_p;
  logic          inc_p;

  mode_t         state;
  mode_t         state_next;

  logic          run;
  logic          sel_hr;
  logic          sel_min;
  logic          sel_sec;
  logic          inc_acc;
  logic          leave_set;
  logic          blink_restart;

  logic [PW-1:0] presc;
  logic          tick;

  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;
  logic          blink_lit;
  logic          blink_lit_next;
  logic [3:0]    blank_next;
  logic [3:0]    blank_q;

  logic          sec_en;
  logic          min_en;
  logic          hr_en;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hr_wrap;
  logic [SW-1:0] sec_cnt;
  logic [MW-1:0] min_cnt;
  logic [HW-1:0] hr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_mode_q <= 1'b0;
      key_inc_q  <= 1'b0;
    end else begin
      key_mode_q <= key_mode;
      key_inc_q  <= key_inc;
    end
  end

  assign mode_p = key_mode & ~key_mode_q;
  assign inc_p  = key_inc & ~key_inc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MODE_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (mode_p) begin
      case (state)
        MODE_RUN:     state_next = MODE_SET_HR;
        MODE_SET_HR:  state_next = MODE_SET_MIN;
        MODE_SET_MIN: state_next = MODE_SET_SEC;
        default:      state_next = MODE_RUN;
      endcase
    end
  end

  // A mode pulse wins over an inc pulse landing on the same edge.
  always_comb begin
    run           = (state == MODE_RUN);
    sel_hr        = (state == MODE_SET_HR);
    sel_min       = (state == MODE_SET_MIN);
    sel_sec       = (state == MODE_SET_SEC);
    inc_acc       = inc_p && !mode_p && !run;
    leave_set     = mode_p && sel_sec;
    blink_restart = mode_p || inc_acc;
    blank_next    = 4'b1111;
    case (state_next)
      MODE_SET_HR:  blank_next[3] = blink_lit_next;
      MODE_SET_MIN: blank_next[2] = blink_lit_next;
      MODE_SET_SEC: blank_next[1] = blink_lit_next;
      default:      blank_next    = 4'b1111;
    endcase
  end

  assign tick = (presc == PW'(CLK_HZ - 1));

  // Clearing on the way back to RUN makes the first second after setting a full one.
  always_ff @(posedge clk) begin
    if (reset || leave_set || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    blink_cnt_next = blink_cnt + 1'b1;
    blink_lit_next = blink_lit;
    if (state_next == MODE_RUN || blink_restart) begin
      blink_cnt_next = '0;
      blink_lit_next = 1'b1;
    end else if (blink_cnt == BW'(HALF - 1)) begin
      blink_cnt_next = '0;
      blink_lit_next = ~blink_lit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_lit <= 1'b1;
      blank_q   <= 4'b1111;
    end else begin
      blink_cnt <= blink_cnt_next;
      blink_lit <= blink_lit_next;
      blank_q   <= blank_next;
    end
  end

  // Carries only ripple in RUN; in a set state each field wraps on its own.
  assign sec_en = (run && tick)     || (sel_sec && inc_acc);
  assign min_en = (run && sec_wrap) || (sel_min && inc_acc);
  assign hr_en  = (run && min_wrap) || (sel_hr && inc_acc);

  wrap_counter #(.MAX(SEC_MAX), .W(SW)) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (sec_en),
    .out   (sec_cnt),
    .wrap  (sec_wrap)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(MW)) u_min (
    .clk   (clk),
    .reset (reset),
    .en    (min_en),
    .out   (min_cnt),
    .wrap  (min_wrap)
  );

  wrap_counter #(.MAX(HOUR_MAX), .W(HW)) u_hr (
    .clk   (clk),
    .reset (reset),
    .en    (hr_en),
    .out   (hr_cnt),
    .wrap  (hr_wrap)
  );

  assign num2  = 8'(hr_cnt);
  assign num1  = 8'(min_cnt);
  assign num0  = 8'(sec_cnt);
  assign blank = blank_q;
  assign mode  = state;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper at CLK_HZ=10, BLINK_HZ=1: directed scenarios plus random
// key activity, all checked each cycle against a seconds-of-day model.
module tb_time_keeper;

  localparam int CLK_HZ   = 10;
  localparam int BLINK_HZ = 1;
  localparam int HOUR_MAX = 23;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
  localparam int DAY      = (HOUR_MAX + 1) * 3600;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_mode;
  logic       key_inc;
  logic [7:0] num2;
  logic [7:0] num1;
  logic [7:0] num0;
  logic [3:0] blank;
  logic [1:0] mode;

  int checks = 0;
  int fails  = 0;

  time_keeper #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .HOUR_MAX(HOUR_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .num2     (num2),
    .num1     (num1),
    .num0     (num0),
    .blank    (blank),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  // Model: time as seconds-of-day, mode as 0..3, prescaler phase, cycles since blink restart.
  int tod   = 0;
  int md    = 0;
  int pre   = 0;
  int since = 0;
  bit kq_m  = 0;
  bit kq_i  = 0;
  bit model_valid = 0;

  function automatic int m_h(); return tod / 3600;        endfunction
  function automatic int m_m(); return (tod / 60) % 60;   endfunction
  function automatic int m_s(); return tod % 60;          endfunction

  function automatic int m_blank();
    bit lit;
    lit = ((since / HALF) % 2) == 0;
    case (md)
      1:       return lit ? 15 : 7;
      2:       return lit ? 15 : 11;
      3:       return lit ? 15 : 13;
      default: return 15;
    endcase
  endfunction

  always @(posedge clk) begin
    bit mp, ip, tk, restart;
    int h, m, s, old_md;
    model_valid = 1;
    if (reset) begin
      tod = 0; md = 0; pre = 0; since = 0; kq_m = 0; kq_i = 0;
    end else begin
      mp = key_mode && !kq_m;
      ip = key_inc && !kq_i;
      kq_m = key_mode;
      kq_i = key_inc;
      tk = (pre == CLK_HZ - 1);
      pre = (pre + 1) % CLK_HZ;
      old_md = md;
      restart = 0;
      h = m_h(); m = m_m(); s = m_s();
      if (old_md == 0 && tk) tod = (tod + 1) % DAY;
      if (mp) begin
        if (old_md == 3) pre = 0;
        md = (md + 1) % 4;
        restart = 1;
      end else if (ip && old_md != 0) begin
        if (old_md == 1) h = (h + 1) % (HOUR_MAX + 1);
        if (old_md == 2) m = (m + 1) % 60;
        if (old_md == 3) s = (s + 1) % 60;
        tod = h * 3600 + m * 60 + s;
        restart = 1;
      end
      since = restart ? 0 : since + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("num2", {24'd0, num2}, m_h());
      check("num1", {24'd0, num1}, m_m());
      check("num0", {24'd0, num0}, m_s());
      check("blank", {28'd0, blank}, m_blank());
      check("mode", {30'd0, mode}, md);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_mode();
    key_mode = 1; cyc(1); key_mode = 0; cyc(1);
  endtask

  task automatic press_inc();
    key_inc = 1; cyc(1); key_inc = 0; cyc(1);
  endtask

  task automatic bump(input int n);
    repeat (n) press_inc();
  endtask

  task automatic lit_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hr"},  {24'd0, num2}, h);
    check({tag, "_min"}, {24'd0, num1}, m);
    check({tag, "_sec"}, {24'd0, num0}, s);
  endtask

  initial begin
    reset = 1; key_mode = 0; key_inc = 0;
    cyc(2);
    lit_time("reset", 0, 0, 0);
    check("reset_blank", {28'd0, blank}, 15);
    check("reset_mode", {30'd0, mode}, 0);
    reset = 0;

    // First tick lands on the tenth edge after release.
    cyc(9);
    check("pre_tick_sec", {24'd0, num0}, 0);
    cyc(1);
    check("first_tick_sec", {24'd0, num0}, 1);
    check("model_first_tick", m_s(), 1);
    cyc(590);
    lit_time("one_minute", 0, 1, 0);
    check("model_one_minute", tod, 60);

    // Set 23:59:59, back to RUN, full-day rollover.
    press_mode();
    bump((23 - m_h() + 24) % 24);
    press_mode();
    bump((59 - m_m() + 60) % 60);
    press_mode();
    bump((59 - m_s() + 60) % 60);
    key_mode = 1; cyc(1); key_mode = 0;
    lit_time("set_2359", 23, 59, 59);
    check("run_mode", {30'd0, mode}, 0);
    cyc(9);
    check("no_early_tick", {24'd0, num0}, 59);
    cyc(1);
    lit_time("rollover", 0, 0, 0);

    // SET_HR blink and frozen time.
    key_mode = 1; cyc(1); key_mode = 0;
    check("sethr_mode", {30'd0, mode}, 1);
    check("sethr_blank0", {28'd0, blank}, 15);
    cyc(4);
    check("sethr_blank4", {28'd0, blank}, 15);
    cyc(1);
    check("sethr_blank5", {28'd0, blank}, 7);
    cyc(5);
    check("sethr_blank10", {28'd0, blank}, 15);
    cyc(40);
    check("frozen_sec", {24'd0, num0}, 0);

    // Field wraps without carry; held key counts once.
    bump(23);
    check("hr_23", {24'd0, num2}, 23);
    press_inc();
    check("hr_wrap", {24'd0, num2}, 0);
    press_mode();
    bump(59);
    check("min_59", {24'd0, num1}, 59);
    press_inc();
    check("min_wrap", {24'd0, num1}, 0);
    check("min_wrap_hr", {24'd0, num2}, 0);
    key_inc = 1; cyc(20); key_inc = 0; cyc(1);
    check("held_inc", {24'd0, num1}, 1);

    // Simultaneous mode and inc: mode wins.
    key_mode = 1; key_inc = 1; cyc(1);
    check("simul_mode", {30'd0, mode}, 3);
    check("simul_min", {24'd0, num1}, 1);
    check("simul_blank", {28'd0, blank}, 15);
    key_mode = 0; key_inc = 0; cyc(1);

    // Reset mid-set at 12:34:56.
    press_mode();
    press_mode();
    bump((12 - m_h() + 24) % 24);
    press_mode();
    bump((34 - m_m() + 60) % 60);
    press_mode();
    bump((56 - m_s() + 60) % 60);
    lit_time("set_123456", 12, 34, 56);
    check("set_sec_mode", {30'd0, mode}, 3);
    reset = 1; cyc(1);
    lit_time("mid_set_reset", 0, 0, 0);
    check("mid_set_mode", {30'd0, mode}, 0);
    check("mid_set_blank", {28'd0, blank}, 15);
    reset = 0; cyc(1);

    // Random key activity with occasional resets and quiet stretches.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) key_mode = ~key_mode;
      if ($urandom_range(0, 3) == 0)  key_inc  = ~key_inc;
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 299) == 0) begin
        key_inc = 0;
        cyc(1);
        reset = 0;
        cyc($urandom_range(20, 200));
      end else begin
        cyc(1);
      end
    end
    reset = 0; key_mode = 0; key_inc = 0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
